// File: rtl/ctrl_pkg.sv
// Shared constants for the down-sampling processor control path: opcodes, ALU op
// encodings, sequencer state encoding and the opcode-to-ALU mapping.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_CLR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_SHR  = 3'b011;
  localparam logic [2:0] ALU_INC  = 3'b100;
  localparam logic [2:0] ALU_CLR  = 3'b101;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLatch,
    StDecode,
    StExecAlu,
    StMemRd,
    StMemWr,
    StFetchOpnd,
    StExecBr,
    StHalt
  } state_e;

  // ALU operation for a register-to-register opcode; anything else passes through.
  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_MOV:  sel = ALU_PASS;
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_SHR:  sel = ALU_SHR;
      OP_INC:  sel = ALU_INC;
      OP_CLR:  sel = ALU_CLR;
      default: sel = ALU_PASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts the cycles a memory read strobe has been held. done is high in the final
// cycle of a MEM_RD_CYCLES-long wait; load re-arms the count for the next wait.
module mem_wait_timer #(
  parameter int unsigned MEM_RD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam logic [3:0] Last = 4'(MEM_RD_CYCLES - 1);

  logic [3:0] cnt_q;

  // Wait counter: cleared on load, advances while a wait is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign done = enable && (cnt_q == Last);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch, latch, decode and execute one instruction at a time.
// All strobes are Moore-decoded from registered state; only the EXEC_BR PC strobes
// look at z_flag directly.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_RD_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op_code,
  input  logic             z_flag,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             inst_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic             imm_sel,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wait_en, wait_done, retire;

  // One timer serves every state that holds mem_rd for a full read.
  assign wait_en = state_q inside {StFetch, StMemRd, StFetchOpnd};

  mem_wait_timer #(
    .MEM_RD_CYCLES(MEM_RD_CYCLES)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (!wait_en || wait_done),
    .enable(wait_en),
    .done  (wait_done)
  );

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q <= op_code;
      end
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign instr_count = cnt_q;

  // An instruction retires when execution hands back to FETCH, or when it halts.
  assign retire = ((state_d == StFetch) &&
                   (state_q inside {StDecode, StExecAlu, StMemRd, StMemWr, StExecBr})) ||
                  ((state_q == StDecode) && (state_d == StHalt));

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (start) state_d = StFetch;
      StFetch:     if (wait_done) state_d = StLatch;
      StLatch:     state_d = StDecode;
      StDecode: begin
        case (op_code)
          OP_MOV, OP_ADD, OP_SUB, OP_SHR, OP_INC, OP_CLR: state_d = StExecAlu;
          OP_LDA:                                         state_d = StMemRd;
          OP_STA:                                         state_d = StMemWr;
          OP_JMP, OP_JNZ, OP_LDI:                         state_d = StFetchOpnd;
          OP_HALT:                                        state_d = StHalt;
          default:                                        state_d = StFetch;
        endcase
      end
      StExecAlu:   state_d = StFetch;
      StMemRd:     if (wait_done) state_d = StFetch;
      StMemWr:     state_d = StFetch;
      StFetchOpnd: if (wait_done) state_d = StExecBr;
      StExecBr:    state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  // Output strobes decoded from the current state.
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    inst_en = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    alu_op  = ALU_PASS;
    reg_we  = 1'b0;
    imm_sel = 1'b0;
    busy    = !(state_q inside {StIdle, StHalt});
    halted  = (state_q == StHalt);
    case (state_q)
      StFetch, StFetchOpnd: mem_rd = 1'b1;
      StLatch: begin
        inst_en = 1'b1;
        pc_inc  = 1'b1;
      end
      StExecAlu: begin
        alu_op = alu_sel(op_q);
        reg_we = 1'b1;
      end
      StMemRd: begin
        mem_rd = 1'b1;
        reg_we = wait_done;
      end
      StMemWr: mem_wr = 1'b1;
      StExecBr: begin
        case (op_q)
          OP_JMP: pc_load = 1'b1;
          OP_JNZ: begin
            // Taken branch loads the operand; not taken skips over it.
            pc_load = !z_flag;
            pc_inc  = z_flag;
          end
          OP_LDI: begin
            reg_we  = 1'b1;
            imm_sel = 1'b1;
            pc_inc  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (read latency 2 and 3) each fed by a small
// instruction-register model; per-cycle strobes are checked against a timeline model.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sel, next_z;
  logic [3:0] next_op;
  int         nrc;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [12:0] obs;
  logic [15:0] cnt_obs;

  logic       start2, start3, z2, z3;
  logic [3:0] op2, op3;
  logic       mem_rd2, mem_wr2, inst_en2, pc_inc2, pc_load2, reg_we2, imm_sel2, busy2, halted2;
  logic       mem_rd3, mem_wr3, inst_en3, pc_inc3, pc_load3, reg_we3, imm_sel3, busy3, halted3;
  logic [2:0] alu_op2, alu_op3;
  logic [15:0] cnt2, cnt3;
  logic [12:0] o2, o3;

  assign start2 = start & ~sel;
  assign start3 = start & sel;
  assign o2 = {mem_rd2, mem_wr2, inst_en2, pc_inc2, pc_load2, alu_op2, reg_we2, imm_sel2,
               busy2, halted2};
  assign o3 = {mem_rd3, mem_wr3, inst_en3, pc_inc3, pc_load3, alu_op3, reg_we3, imm_sel3,
               busy3, halted3};

  control_unit #(.MEM_RD_CYCLES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_code(op2), .z_flag(z2),
    .mem_rd(mem_rd2), .mem_wr(mem_wr2), .inst_en(inst_en2), .pc_inc(pc_inc2),
    .pc_load(pc_load2), .alu_op(alu_op2), .reg_we(reg_we2), .imm_sel(imm_sel2),
    .busy(busy2), .halted(halted2), .instr_count(cnt2)
  );

  control_unit #(.MEM_RD_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op_code(op3), .z_flag(z3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .inst_en(inst_en3), .pc_inc(pc_inc3),
    .pc_load(pc_load3), .alu_op(alu_op3), .reg_we(reg_we3), .imm_sel(imm_sel3),
    .busy(busy3), .halted(halted3), .instr_count(cnt3)
  );

  // Instruction register model: captures the pending instruction on the falling edge.
  always @(negedge clk) begin
    if (inst_en2 === 1'b1) begin
      op2 <= next_op;
      z2  <= next_z;
    end
    if (inst_en3 === 1'b1) begin
      op3 <= next_op;
      z3  <= next_z;
    end
  end

  // Total cycles an instruction spends from its first FETCH cycle to its last cycle.
  function automatic int ilen(input logic [3:0] op, input int n);
    if (op == 4'd2 || (op >= 4'd3 && op <= 4'd8)) return n + 3;
    if (op == 4'd1) return 2 * n + 2;
    if (op >= 4'd9 && op <= 4'd11) return 2 * n + 3;
    return n + 2;
  endfunction

  // Expected strobe vector k cycles into an instruction.
  function automatic logic [12:0] vec(input logic [3:0] op, input logic z, input int n,
                                      input int k);
    logic rd, wr, ie, inc, ld, we, imm;
    logic [2:0] alu;
    rd = 0; wr = 0; ie = 0; inc = 0; ld = 0; we = 0; imm = 0; alu = 3'd0;
    if (k < n) rd = 1;
    else if (k == n) begin ie = 1; inc = 1; end
    else if (k == n + 1) rd = 0;
    else if (op >= 4'd3 && op <= 4'd8) begin alu = 3'(op - 4'd3); we = 1; end
    else if (op == 4'd2) wr = 1;
    else if (op == 4'd1) begin rd = 1; we = (k == 2 * n + 1); end
    else if (op >= 4'd9 && op <= 4'd11) begin
      if (k <= 2 * n + 1) rd = 1;
      else if (op == 4'd9) ld = 1;
      else if (op == 4'd10) begin inc = z; ld = !z; end
      else begin we = 1; imm = 1; inc = 1; end
    end
    return {rd, wr, ie, inc, ld, alu, we, imm, 1'b1, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    obs     = sel ? o3 : o2;
    cnt_obs = sel ? cnt3 : cnt2;
  endtask

  task automatic begin_prog(input logic s);
    sel = s;
    nrc = s ? 3 : 2;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    @(posedge clk);
    #1;
    n_tests++; if (o2 !== 13'd0) begin n_fail++; $display("FAIL reset_out2 got=%b exp=0", o2); end
    n_tests++; if (o3 !== 13'd0) begin n_fail++; $display("FAIL reset_out3 got=%b exp=0", o3); end
    n_tests++; if (cnt2 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
    n_tests++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt3 got=%0d exp=0", cnt3); end
    rst = 1'b0;
    repeat (3) begin
      step();
      n_tests++;
      if (o2 !== 13'd0 || o3 !== 13'd0) begin
        n_fail++; $display("FAIL idle_no_start got=%b/%b exp=0", o2, o3);
      end
    end
  endtask

  task automatic test_add();
    logic [3:0] ops [2] = '{4'h4, 4'h0};
    begin_prog(1'b0);
    for (int i = 0; i < 2; i++) begin
      next_op = ops[i]; next_z = 1'b0;
      for (int k = 0; k < ilen(ops[i], nrc); k++) begin
        step();
        start = 1'b0;
        n_tests++;
        if (obs !== vec(ops[i], 1'b0, nrc, k)) begin
          n_fail++;
          $display("FAIL add op=%h k=%0d got=%b exp=%b", ops[i], k, obs, vec(ops[i], 1'b0, nrc, k));
        end
        if (k == 0) begin
          n_tests++;
          if (cnt_obs !== 16'(i)) begin n_fail++; $display("FAIL add_cnt got=%0d exp=%0d", cnt_obs, i); end
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0] ops [5] = '{4'hA, 4'hA, 4'h9, 4'hB, 4'h0};
    logic       zs  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    begin_prog(1'b0);
    for (int i = 0; i < 5; i++) begin
      next_op = ops[i]; next_z = zs[i];
      for (int k = 0; k < ilen(ops[i], nrc); k++) begin
        step();
        start = 1'b0;
        n_tests++;
        if (obs !== vec(ops[i], zs[i], nrc, k)) begin
          n_fail++;
          $display("FAIL branch op=%h z=%0d k=%0d got=%b exp=%b", ops[i], zs[i], k, obs,
                   vec(ops[i], zs[i], nrc, k));
        end
        if (k == 0) begin
          n_tests++;
          if (cnt_obs !== 16'(i)) begin n_fail++; $display("FAIL branch_cnt got=%0d exp=%0d", cnt_obs, i); end
        end
      end
    end
  endtask

  task automatic test_lda3();
    logic [3:0] ops [4] = '{4'h1, 4'h2, 4'h1, 4'h0};
    begin_prog(1'b1);
    for (int i = 0; i < 4; i++) begin
      next_op = ops[i]; next_z = 1'b0;
      for (int k = 0; k < ilen(ops[i], nrc); k++) begin
        step();
        start = 1'b0;
        n_tests++;
        if (obs !== vec(ops[i], 1'b0, nrc, k)) begin
          n_fail++;
          $display("FAIL lda3 op=%h k=%0d got=%b exp=%b", ops[i], k, obs, vec(ops[i], 1'b0, nrc, k));
        end
        if (k == 0) begin
          n_tests++;
          if (cnt_obs !== 16'(i)) begin n_fail++; $display("FAIL lda3_cnt got=%0d exp=%0d", cnt_obs, i); end
        end
      end
    end
  endtask

  task automatic test_reserved();
    logic [3:0] ops [4] = '{4'hD, 4'hC, 4'hE, 4'h0};
    begin_prog(1'b0);
    for (int i = 0; i < 4; i++) begin
      next_op = ops[i]; next_z = 1'b0;
      for (int k = 0; k < ilen(ops[i], nrc); k++) begin
        step();
        start = 1'b0;
        n_tests++;
        if (obs !== vec(ops[i], 1'b0, nrc, k)) begin
          n_fail++;
          $display("FAIL reserved op=%h k=%0d got=%b exp=%b", ops[i], k, obs, vec(ops[i], 1'b0, nrc, k));
        end
        if (k == 0) begin
          n_tests++;
          if (cnt_obs !== 16'(i)) begin n_fail++; $display("FAIL reserved_cnt got=%0d exp=%0d", cnt_obs, i); end
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [3:0] ops [2] = '{4'h0, 4'hF};
    begin_prog(1'b0);
    for (int i = 0; i < 2; i++) begin
      next_op = ops[i]; next_z = 1'b0;
      for (int k = 0; k < ilen(ops[i], nrc); k++) begin
        step();
        start = 1'b0;
        n_tests++;
        if (obs !== vec(ops[i], 1'b0, nrc, k)) begin
          n_fail++;
          $display("FAIL halt_seq op=%h k=%0d got=%b exp=%b", ops[i], k, obs, vec(ops[i], 1'b0, nrc, k));
        end
      end
    end
    // Parked in HALT: only halted is high, start has no effect.
    for (int c = 0; c < 21; c++) begin
      step();
      start = ($urandom_range(0, 1) == 1);
      n_tests++;
      if (obs !== 13'b1 || cnt_obs !== 16'd2) begin
        n_fail++; $display("FAIL halt_hold c=%0d got=%b cnt=%0d exp=%b cnt=2", c, obs, cnt_obs, 13'b1);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (o2 !== 13'd0 || cnt2 !== 16'd0) begin
      n_fail++; $display("FAIL halt_reset got=%b cnt=%0d exp=0 cnt=0", o2, cnt2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    begin_prog(1'b0);
    next_op = 4'h9; next_z = 1'b0;
    for (int k = 0; k <= nrc + 2; k++) begin
      step();
      start = 1'b0;
    end
    n_tests++;
    if (obs !== vec(4'h9, 1'b0, nrc, nrc + 2)) begin
      n_fail++; $display("FAIL mid_opnd got=%b exp=%b", obs, vec(4'h9, 1'b0, nrc, nrc + 2));
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_rd2 !== 1'b0 || o2 !== 13'd0) begin
      n_fail++; $display("FAIL mid_async_drop got=%b exp=0", o2);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if (obs !== 13'd0 || cnt_obs !== 16'd0) begin
        n_fail++; $display("FAIL mid_idle c=%0d got=%b cnt=%0d exp=0 cnt=0", c, obs, cnt_obs);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic       z;
    for (int s = 0; s < 2; s++) begin
      begin_prog(s[0]);
      for (int i = 0; i < 25; i++) begin
        op = 4'($urandom_range(0, 14));
        z  = ($urandom_range(0, 1) == 1);
        next_op = op; next_z = z;
        for (int k = 0; k < ilen(op, nrc); k++) begin
          step();
          start = 1'b0;
          n_tests++;
          if (obs !== vec(op, z, nrc, k)) begin
            n_fail++;
            $display("FAIL random n=%0d op=%h z=%0d k=%0d got=%b exp=%b", nrc, op, z, k, obs,
                     vec(op, z, nrc, k));
          end
          if (k == 0) begin
            n_tests++;
            if (cnt_obs !== 16'(i)) begin
              n_fail++; $display("FAIL random_cnt n=%0d got=%0d exp=%0d", nrc, cnt_obs, i);
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; nrc = 2;
    next_op = 4'h0; next_z = 1'b0;
    op2 = 4'h0; op3 = 4'h0; z2 = 1'b0; z3 = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_lda3();
    test_reserved();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the down-sampling processor.
- Runs fetch, latch, decode and execute for each instruction.
- Drives the instruction-register load enable (inst_en), the PC increment/load strobes, memory read/write strobes, the ALU op select and the register-file write enable.
- Consumes the opcode decoded by the instruction register and the ALU zero flag.

Parameters:
MEM_RD_CYCLES, 2, cycles a memory read strobe is held before data is valid (legal range 1..15)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin execution from IDLE; ignored in all other states
op_code  in  4  opcode from instruction register
z_flag  in  1  ALU zero flag, sampled in EXEC_BR
mem_rd  out  1  memory read strobe (address = PC, or data address in MEM_RD)
mem_wr  out  1  memory write strobe
inst_en  out  1  instruction register load; register captures on falling edge
pc_inc  out  1  PC += 1 this cycle
pc_load  out  1  PC <= operand byte (instruction-register pass-through) this cycle
alu_op  out  3  000 PASS/MOV, 001 ADD, 010 SUB, 011 SHR, 100 INC, 101 CLR; 000 when idle
reg_we  out  1  register-file write enable
imm_sel  out  1  register write source = operand byte instead of ALU/memory
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
instr_count  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, instr_count=0, all outputs 0.
- Outputs are Moore-decoded from registered state; there is no combinational path from op_code or z_flag to outputs, except pc_load/pc_inc in EXEC_BR.
- Opcodes:
  - 0 NOP, 1 LDA, 2 STA, 3 MOV, 4 ADD, 5 SUB, 6 SHR, 7 INC, 8 CLR, 9 JMP, A JNZ, B LDI, F HALT.
  - C-E are reserved and execute as NOP.
- States and transitions:
  - IDLE: outputs 0. start=1 -> FETCH.
  - FETCH: mem_rd=1 for exactly MEM_RD_CYCLES cycles (wait counter), then -> LATCH.
  - LATCH: inst_en=1, pc_inc=1, one cycle, -> DECODE. op_code is valid from the next rising edge.
  - DECODE: one cycle, sample op_code:
    - 3-8 -> EXEC_ALU
    - 1 -> MEM_RD
    - 2 -> MEM_WR
    - 9, A, B -> FETCH_OPND
    - F -> HALT
    - 0, C-E -> FETCH (retire)
  - EXEC_ALU: alu_op per opcode, reg_we=1, one cycle -> FETCH.
  - MEM_RD: mem_rd=1 for MEM_RD_CYCLES cycles; reg_we=1 in the last cycle only -> FETCH.
  - MEM_WR: mem_wr=1, one cycle -> FETCH.
  - FETCH_OPND: mem_rd=1 for MEM_RD_CYCLES cycles (address=PC) -> EXEC_BR.
  - EXEC_BR: one cycle, strobes depend on opcode, -> FETCH:
    - JMP: pc_load=1.
    - JNZ: z_flag=0 -> pc_load=1; z_flag=1 -> pc_inc=1 (skip operand).
    - LDI: reg_we=1, imm_sel=1, pc_inc=1.
  - HALT: halted=1, all strobes 0. Terminal; leave only via rst. start ignored.
- Exactly one of pc_inc and pc_load may be high in any cycle. mem_rd and mem_wr are never both high.
- instr_count increments by 1 on each transition into FETCH from DECODE, EXEC_ALU, MEM_RD, MEM_WR or EXEC_BR, and on DECODE->HALT. It is not incremented on IDLE->FETCH.
- Cycle counts at MEM_RD_CYCLES=2:
  - NOP: 4
  - ALU ops and STA: 5
  - LDA: 6
  - JMP, JNZ, LDI: 7
- Reset mid-operation: immediate return to IDLE. Any in-flight strobe drops asynchronously.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_NOP..OP_HALT)
  - alu_op encodings (ALU_PASS..ALU_CLR)
  - state encoding
- Sub-module mem_wait_timer, parameter MEM_RD_CYCLES:
  - inputs: load, enable
  - output: done, high in the final wait cycle
  - shared by FETCH, MEM_RD and FETCH_OPND.

Test Plan:
- Reset then start=1, op_code=4 (ADD):
  - mem_rd high 2 cycles, then inst_en+pc_inc 1 cycle, DECODE, then alu_op=001 with reg_we=1 for 1 cycle.
  - instr_count=1 at the next FETCH.
- JNZ with z_flag=0: pc_load pulses once in EXEC_BR, pc_inc does not. Repeat with z_flag=1: pc_inc pulses, pc_load does not.
- LDA with MEM_RD_CYCLES=3: mem_rd high 3 cycles in MEM_RD, reg_we only in the 3rd cycle, total 8 cycles.
- Opcode D (reserved): DECODE->FETCH directly, no reg_we/mem_wr/pc_load, instr_count increments.
- Opcode F: halted=1, busy=0, start pulses ignored for 20 cycles. rst -> IDLE, instr_count=0.
- Assert rst mid-FETCH_OPND: mem_rd drops before the next clock edge. After release, state=IDLE, all outputs 0.
